mem_arbiter: RTL and testbench

//  Two-master to one-slave arbiter on the 128-bit line-fill/write-back memory bus, downstream of the cache.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arbiter_rr_arb2.sv | 15 +
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and beat-count helpers for the two-master line-fill/write-back arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

    localparam int BANK_NUM_DEF = 4;

    // Two cache banks travel per bus beat; a transaction always has at least one beat.
    function automatic int calc_beats(input int bank_num);
        int beats;
        beats = bank_num / 2;
        if (beats < 1) begin
            beats = 1;
        end else begin
            beats = beats;
        end
        return beats;
    endfunction

    localparam int BEATS = calc_beats(BANK_NUM_DEF);
    localparam int CNT_W = $clog2(BEATS + 1);

    typedef logic [CNT_W-1:0] beat_cnt_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; ptr names the master preferred on a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // A master wins when it is the only requestor or when it holds the preference
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~ptr);
        gnt[1] = req[1] & (~req[0] | ptr);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory bus arbiter: whole-transaction grants, round-robin
// between the instruction and data caches, responses routed back only to the owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BANK_NUM   = BANK_NUM_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      m0_ren,
    input  logic [ADDR_WIDTH-1:0]     m0_raddr,
    input  logic                      m0_wen,
    input  logic [ADDR_WIDTH-1:0]     m0_waddr,
    input  logic [2*DATA_WIDTH-1:0]   m0_wdata,
    input  logic [2*DATA_WIDTH/8-1:0] m0_wmask,
    output logic [2*DATA_WIDTH-1:0]   m0_rdata,
    output logic                      m0_rvalid,
    output logic                      m0_wvalid,
    input  logic                      m1_ren,
    input  logic [ADDR_WIDTH-1:0]     m1_raddr,
    input  logic                      m1_wen,
    input  logic [ADDR_WIDTH-1:0]     m1_waddr,
    input  logic [2*DATA_WIDTH-1:0]   m1_wdata,
    input  logic [2*DATA_WIDTH/8-1:0] m1_wmask,
    output logic [2*DATA_WIDTH-1:0]   m1_rdata,
    output logic                      m1_rvalid,
    output logic                      m1_wvalid,
    output logic                      s_ren,
    output logic [ADDR_WIDTH-1:0]     s_raddr,
    output logic                      s_wen,
    output logic [ADDR_WIDTH-1:0]     s_waddr,
    output logic [2*DATA_WIDTH-1:0]   s_wdata,
    output logic [2*DATA_WIDTH/8-1:0] s_wmask,
    input  logic [2*DATA_WIDTH-1:0]   s_rdata,
    input  logic                      s_rvalid,
    input  logic                      s_wvalid
);

    localparam int BW        = 2 * DATA_WIDTH;
    localparam int MW        = 2 * DATA_WIDTH / 8;
    localparam int TXN_BEATS = calc_beats(BANK_NUM);
    localparam int CW        = $clog2(TXN_BEATS + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(TXN_BEATS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    arb_state_t    state_r, state_nxt_s;
    logic          owner_r, owner_nxt_s;
    logic          rr_ptr_r, rr_ptr_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [1:0]    req_s, gnt_s;
    logic          beat_done_s;

    assign req_s = {m1_ren | m1_wen, m0_ren | m0_wen};

    rr_arb2 u_rr_arb2 (
        .req (req_s),
        .ptr (rr_ptr_r),
        .gnt (gnt_s)
    );

    // Only a completion matching the current direction advances the transaction
    assign beat_done_s = ((state_r == RD) & s_rvalid) | ((state_r == WR) & s_wvalid);

    // State, owner, beat counter and round-robin pointer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            owner_r  <= 1'b0;
            rr_ptr_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            owner_r  <= owner_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Next-state: arbitrate in IDLE, then hold the grant until the last beat completes
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        rr_ptr_nxt_s = rr_ptr_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = {CW{1'b0}};
                if (gnt_s != 2'b00) begin
                    owner_nxt_s = gnt_s[1];
                    // A master asking for both is served as a read first
                    if (gnt_s[1] ? m1_ren : m0_ren) begin
                        state_nxt_s = RD;
                    end else begin
                        state_nxt_s = WR;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD, WR: begin
                if (beat_done_s) begin
                    if (cnt_r == LAST_BEAT) begin
                        state_nxt_s  = IDLE;
                        cnt_nxt_s    = {CW{1'b0}};
                        rr_ptr_nxt_s = ~owner_r;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output muxes: forward the owner's request, steer completions to the owner only
    always_comb begin
        s_ren   = 1'b0;
        s_raddr = {ADDR_WIDTH{1'b0}};
        s_wen   = 1'b0;
        s_waddr = {ADDR_WIDTH{1'b0}};
        s_wdata = {BW{1'b0}};
        s_wmask = {MW{1'b0}};
        case (state_r)
            RD: begin
                s_ren   = owner_r ? m1_ren : m0_ren;
                s_raddr = owner_r ? m1_raddr : m0_raddr;
            end
            WR: begin
                s_wen   = owner_r ? m1_wen : m0_wen;
                s_waddr = owner_r ? m1_waddr : m0_waddr;
                s_wdata = owner_r ? m1_wdata : m0_wdata;
                s_wmask = owner_r ? m1_wmask : m0_wmask;
            end
            default: begin
                s_ren = 1'b0;
                s_wen = 1'b0;
            end
        endcase
        m0_rvalid = s_rvalid & (state_r == RD) & ~owner_r;
        m1_rvalid = s_rvalid & (state_r == RD) & owner_r;
        m0_wvalid = s_wvalid & (state_r == WR) & ~owner_r;
        m1_wvalid = s_wvalid & (state_r == WR) & owner_r;
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an arbitration vector table plus multi-cycle
// transaction sequences against a fixed-latency memory model.
module tb_mem_arbiter;

    localparam int AW    = 64;
    localparam int BW    = 128;
    localparam int MW    = 16;
    localparam int BEATS = 2;
    localparam logic [63:0] RD_TAG = 64'hDA7A_DA7A_DA7A_DA7A;

    logic clk = 1'b0;
    logic rstn;
    logic m0_ren, m0_wen, m1_ren, m1_wen;
    logic [AW-1:0] m0_raddr, m0_waddr, m1_raddr, m1_waddr;
    logic [BW-1:0] m0_wdata, m1_wdata;
    logic [MW-1:0] m0_wmask, m1_wmask;
    logic [BW-1:0] m0_rdata, m1_rdata;
    logic m0_rvalid, m0_wvalid, m1_rvalid, m1_wvalid;
    logic s_ren, s_wen;
    logic [AW-1:0] s_raddr, s_waddr;
    logic [BW-1:0] s_wdata;
    logic [MW-1:0] s_wmask;
    logic [BW-1:0] s_rdata = 128'h1234_5678;
    logic slv_rvalid = 1'b0;
    logic slv_wvalid = 1'b0;
    logic inj_rv, inj_wv;

    int checks = 0;
    int errors = 0;

    int res_rv [2];
    int res_wv [2];
    int order [$];
    int leak, viol, idle_cyc, first_cyc, sren_seen;
    int slv_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .m0_ren(m0_ren), .m0_raddr(m0_raddr), .m0_wen(m0_wen), .m0_waddr(m0_waddr),
        .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rdata(m0_rdata),
        .m0_rvalid(m0_rvalid), .m0_wvalid(m0_wvalid),
        .m1_ren(m1_ren), .m1_raddr(m1_raddr), .m1_wen(m1_wen), .m1_waddr(m1_waddr),
        .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rdata(m1_rdata),
        .m1_rvalid(m1_rvalid), .m1_wvalid(m1_wvalid),
        .s_ren(s_ren), .s_raddr(s_raddr), .s_wen(s_wen), .s_waddr(s_waddr),
        .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rdata(s_rdata),
        .s_rvalid(slv_rvalid | inj_rv), .s_wvalid(slv_wvalid | inj_wv)
    );

    // Memory model: completes a beat on the third consecutive cycle it sees a request
    always begin
        @(posedge clk);
        #1;
        slv_rvalid = 1'b0;
        slv_wvalid = 1'b0;
        if (!rstn || !(s_ren || s_wen)) begin
            slv_cnt = 0;
        end else begin
            slv_cnt++;
            if (slv_cnt == 3) begin
                slv_cnt = 0;
                if (s_ren) begin
                    slv_rvalid = 1'b1;
                    s_rdata    = {RD_TAG, s_raddr};
                end else begin
                    slv_wvalid = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int ord(input int i);
        return (i < order.size()) ? order[i] : -1;
    endfunction

    task automatic do_reset();
        rstn   = 1'b0;
        m0_ren = 1'b0; m0_wen = 1'b0; m1_ren = 1'b0; m1_wen = 1'b0;
        inj_rv = 1'b0; inj_wv = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    // Lets a just-finished transaction retire, then checks IDLE latency and the preferred master
    task automatic idle_probe(input string nm, input bit exp_m1);
        step();
        m0_raddr = 64'h6000; m1_raddr = 64'h7000;
        m0_wen = 1'b0; m1_wen = 1'b0;
        m0_ren = 1'b1; m1_ren = 1'b1;
        #1;
        chk({nm, "_idle"}, s_ren, 1'b0);
        step();
        chk({nm, "_winner"}, s_raddr, exp_m1 ? 64'h7000 : 64'h6000);
        do_reset();
    endtask

    // Runs whole transactions for the requested masters, acting as both cache controllers
    task automatic run(input bit r0, input bit w0, input bit r1, input bit w1,
                       input int m1_delay, input bit gap0, input bit from_idle);
        int  rc [2];
        int  wc [2];
        bit  gap_pend, m1_go, all_done;
        rc = '{0, 0}; wc = '{0, 0};
        gap_pend = 1'b0; all_done = 1'b0;
        order.delete();
        leak = 0; viol = 0; idle_cyc = 0; first_cyc = -1; sren_seen = 0;
        m0_raddr = 64'h5000; m0_waddr = 64'h4000;
        m1_raddr = 64'h1000; m1_waddr = 64'h2000;
        m0_wdata = {4{32'h5A5A_0F0F}}; m0_wmask = 16'h00ff;
        m1_wdata = {4{32'hA5A5_A5A5}}; m1_wmask = 16'hffff;
        m0_ren = r0; m0_wen = w0;
        m1_go  = (m1_delay == 0);
        m1_ren = m1_go ? r1 : 1'b0;
        m1_wen = m1_go ? w1 : 1'b0;
        if (from_idle) begin
            #1;
            chk("latency_no_same_cycle", {s_ren, s_wen}, 2'b00);
        end
        for (int cyc = 1; cyc <= 80 && !all_done; cyc++) begin
            step();
            if ((s_ren || s_wen) && first_cyc < 0) first_cyc = cyc;
            if (s_ren) sren_seen++;
            if (first_cyc > 0 && !s_ren && !s_wen) idle_cyc++;
            if (s_ren && s_wen) viol++;
            if ((m0_rvalid || m0_wvalid) && (m1_rvalid || m1_wvalid)) viol++;
            if (s_wen && !((m0_wen && s_waddr == m0_waddr && s_wdata == m0_wdata && s_wmask == m0_wmask) ||
                           (m1_wen && s_waddr == m1_waddr && s_wdata == m1_wdata && s_wmask == m1_wmask)))
                viol++;
            if (s_ren && s_raddr[15:12] == 4'h1 && rc[0] >= 1 && rc[0] < BEATS) leak++;
            if (m0_rvalid) begin
                chk("m0_rdata", m0_rdata, {RD_TAG, m0_raddr});
                rc[0]++;
                if (rc[0] == BEATS) begin
                    m0_ren = 1'b0;
                    order.push_back(0);
                end else begin
                    m0_raddr += 64'h10;
                    if (gap0) begin
                        m0_ren = 1'b0;
                        gap_pend = 1'b1;
                    end
                end
            end else if (gap_pend) begin
                m0_ren = 1'b1;
                gap_pend = 1'b0;
            end
            if (m0_wvalid) begin
                wc[0]++;
                if (wc[0] == BEATS) begin m0_wen = 1'b0; order.push_back(2); end
                else m0_waddr += 64'h10;
            end
            if (m1_rvalid) begin
                chk("m1_rdata", m1_rdata, {RD_TAG, m1_raddr});
                rc[1]++;
                if (rc[1] == BEATS) begin m1_ren = 1'b0; order.push_back(1); end
                else m1_raddr += 64'h10;
            end
            if (m1_wvalid) begin
                wc[1]++;
                if (wc[1] == BEATS) begin m1_wen = 1'b0; order.push_back(3); end
                else m1_waddr += 64'h10;
            end
            if (!m1_go && rc[0] >= m1_delay) begin
                m1_ren = r1; m1_wen = w1; m1_go = 1'b1;
            end
            all_done = (!r0 || rc[0] >= BEATS) && (!w0 || wc[0] >= BEATS) &&
                       (!r1 || rc[1] >= BEATS) && (!w1 || wc[1] >= BEATS);
        end
        checks++;
        if (!all_done) begin
            errors++;
            $display("FAIL txn_timeout actual=rd%0d/%0d wr%0d/%0d required=complete", rc[0], rc[1], wc[0], wc[1]);
        end
        res_rv = rc;
        res_wv = wc;
    endtask

    typedef struct {
        bit          ptr1;
        logic [3:0]  req;        // {m0_ren, m0_wen, m1_ren, m1_wen}
        logic        exp_ren;
        logic        exp_wen;
        logic [63:0] exp_raddr;
        logic [63:0] exp_waddr;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 64'h0,  64'hD0};
        vecs[1]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 64'hA0, 64'h0};
        vecs[2]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 64'h0,  64'hC0};
        vecs[3]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 64'hB0, 64'h0};
        vecs[4]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 64'hA0, 64'h0};
        vecs[5]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 64'h0,  64'hC0};
        vecs[6]  = '{1'b0, 4'b1100, 1'b1, 1'b0, 64'hA0, 64'h0};
        vecs[7]  = '{1'b0, 4'b0011, 1'b1, 1'b0, 64'hB0, 64'h0};
        vecs[8]  = '{1'b1, 4'b1010, 1'b1, 1'b0, 64'hB0, 64'h0};
        vecs[9]  = '{1'b1, 4'b0110, 1'b1, 1'b0, 64'hB0, 64'h0};
        vecs[10] = '{1'b1, 4'b1001, 1'b0, 1'b1, 64'h0,  64'hD0};
        vecs[11] = '{1'b1, 4'b1000, 1'b1, 1'b0, 64'hA0, 64'h0};
        vecs[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 64'h0,  64'h0};

        rstn = 1'b0;
        m0_ren = 1'b0; m0_wen = 1'b0; m1_ren = 1'b0; m1_wen = 1'b0;
        m0_raddr = 64'h0; m0_waddr = 64'h0; m1_raddr = 64'h0; m1_waddr = 64'h0;
        m0_wdata = 128'h0; m1_wdata = 128'h0; m0_wmask = 16'h0; m1_wmask = 16'h0;
        inj_rv = 1'b0; inj_wv = 1'b0;
        #1;
        chk("rst_s_req", {s_ren, s_wen, s_raddr, s_waddr}, 130'h0);
        chk("rst_s_wr", {s_wdata, s_wmask}, 144'h0);
        chk("rst_valids", {m0_rvalid, m0_wvalid, m1_rvalid, m1_wvalid}, 4'b0000);
        chk("rst_rdata", {m0_rdata, m1_rdata}, {128'h1234_5678, 128'h1234_5678});

        // Arbitration table: one grant cycle from IDLE, optionally after an m0 transaction
        foreach (vecs[i]) begin
            do_reset();
            if (vecs[i].ptr1) begin
                run(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
                step();
            end
            m0_raddr = 64'hA0; m1_raddr = 64'hB0; m0_waddr = 64'hC0; m1_waddr = 64'hD0;
            {m0_ren, m0_wen, m1_ren, m1_wen} = vecs[i].req;
            #1;
            chk($sformatf("vec%0d_lat", i), {s_ren, s_wen}, 2'b00);
            step();
            chk($sformatf("vec%0d_ren_wen", i), {s_ren, s_wen}, {vecs[i].exp_ren, vecs[i].exp_wen});
            chk($sformatf("vec%0d_raddr", i), s_raddr, vecs[i].exp_raddr);
            chk($sformatf("vec%0d_waddr", i), s_waddr, vecs[i].exp_waddr);
        end

        // Single m1 read
        do_reset();
        run(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        chk("t1_first_sren_cycle", first_cyc, 1);
        chk("t1_m1_rvalid", res_rv[1], 2);
        chk("t1_m0_rvalid", res_rv[0], 0);
        idle_probe("t1", 1'b0);

        // Simultaneous reads after reset
        run(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        chk("t2_order", {ord(0), ord(1)}, {32'd0, 32'd1});
        chk("t2_beats", {res_rv[0], res_rv[1]}, {32'd2, 32'd2});
        chk("t2_viol", viol, 0);
        idle_probe("t2", 1'b0);

        // Grant held through an m0 gap while m1 waits
        run(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1);
        chk("t3_leak", leak, 0);
        chk("t3_order", {ord(0), ord(1)}, {32'd0, 32'd1});
        chk("t3_beats", {res_rv[0], res_rv[1]}, {32'd2, 32'd2});

        // m1 write-back
        do_reset();
        run(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        chk("t4_m1_wvalid", res_wv[1], 2);
        chk("t4_m0_wvalid", res_wv[0], 0);
        chk("t4_sren_seen", sren_seen, 0);
        chk("t4_mirror", viol, 0);
        idle_probe("t4", 1'b0);

        // m0 read and write together: read transaction, one idle cycle, write transaction
        run(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("t5_beats", {res_rv[0], res_wv[0]}, {32'd2, 32'd2});
        chk("t5_order", {ord(0), ord(1)}, {32'd0, 32'd2});
        chk("t5_idle_cycles", idle_cyc, 1);
        idle_probe("t5", 1'b1);

        // Reset in the middle of a read, right in a beat-complete cycle
        m0_raddr = 64'h5000;
        m0_ren = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                seen = m0_rvalid;
            end
            chk("t6_first_beat_seen", seen, 1'b1);
        end
        rstn = 1'b0;
        m0_ren = 1'b0;
        #1;
        chk("t6_s_out", {s_ren, s_wen, s_raddr, s_waddr, s_wdata, s_wmask}, 274'h0);
        chk("t6_valids", {m0_rvalid, m0_wvalid, m1_rvalid, m1_wvalid}, 4'b0000);
        chk("t6_rdata_follow", m0_rdata, s_rdata);
        step();
        rstn = 1'b1;
        run(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("t6_new_read_beats", res_rv[0], 2);
        idle_probe("t6", 1'b1);

        // Stray read completion while IDLE
        inj_rv = 1'b1;
        #1;
        chk("t7_idle_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        step();
        inj_rv = 1'b0;
        run(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("t7_beats", res_rv[0], 2);
        idle_probe("t7", 1'b1);

        // Stray write completion during a read
        m0_raddr = 64'h5000;
        m0_ren = 1'b1;
        step();
        inj_wv = 1'b1;
        #1;
        chk("t8_rd_wvalid", {m0_wvalid, m1_wvalid}, 2'b00);
        step();
        inj_wv = 1'b0;
        run(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("t8_beats", res_rv[0], 2);
        idle_probe("t8", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
